// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared defaults for the N-way data-cache storage array. The default
// geometry matches the 2-way array this block replaces. WAY_W and IDX_W
// are the way-select and set-index widths implied by that geometry. They
// are the default widths of the request/response interface.
package dcache_pkg;

    localparam int DEF_SETS   = 16;
    localparam int DEF_WAYS   = 2;
    localparam int DEF_TAG_W  = 23;
    localparam int DEF_LINE_W = 256;

    localparam int WAY_W = $clog2(DEF_WAYS);
    localparam int IDX_W = $clog2(DEF_SETS);

endpackage

// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if
// Request/response bundle between the dcache controller and the storage
// array.
//   request  : req_i, we_i, index_i, tag_i, data_i, dirty_i
//   response : rsp_valid_o, hit_o, way_o, data_o,
//              victim_valid_o, victim_dirty_o, victim_tag_o, victim_data_o
// The master modport is the controller side. The slave modport is the
// array side. The _i/_o suffixes are seen from the array.
interface dcache_sram_nway_if
    import dcache_pkg::*;
#(
    parameter int IDX_BITS = IDX_W,
    parameter int WAY_BITS = WAY_W,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int LINE_W   = DEF_LINE_W
);
    logic                req_i;
    logic                we_i;
    logic [IDX_BITS-1:0] index_i;
    logic [TAG_W-1:0]    tag_i;
    logic [LINE_W-1:0]   data_i;
    logic                dirty_i;

    logic                rsp_valid_o;
    logic                hit_o;
    logic [WAY_BITS-1:0] way_o;
    logic [LINE_W-1:0]   data_o;
    logic                victim_valid_o;
    logic                victim_dirty_o;
    logic [TAG_W-1:0]    victim_tag_o;
    logic [LINE_W-1:0]   victim_data_o;

    modport master (
        output req_i, we_i, index_i, tag_i, data_i, dirty_i,
        input  rsp_valid_o, hit_o, way_o, data_o,
               victim_valid_o, victim_dirty_o, victim_tag_o, victim_data_o
    );

    modport slave (
        input  req_i, we_i, index_i, tag_i, data_i, dirty_i,
        output rsp_valid_o, hit_o, way_o, data_o,
               victim_valid_o, victim_dirty_o, victim_tag_o, victim_data_o
    );

endinterface

// File: rtl/dcache_sram_nway_lru.sv
// dcache_lru
// True-LRU age storage for every set. It also performs the victim select
// for the set being addressed.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   index        : set being addressed this cycle
//   set_valid    : valid bits of that set (used for the victim choice)
//   touch        : make touch_way the MRU way of the set on this edge
//   touch_way    : way to promote
//   victim_way   : lowest invalid way, else the way whose age is WAYS-1
// Ages in a set always form a permutation of 0..WAYS-1. Age 0 is MRU.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS = DEF_SETS,
    parameter int WAYS = DEF_WAYS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$clog2(SETS)-1:0]  index,
    input  logic [WAYS-1:0]          set_valid,
    input  logic                     touch,
    input  logic [$clog2(WAYS)-1:0]  touch_way,
    output logic [$clog2(WAYS)-1:0]  victim_way
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic [WAY_BITS-1:0] age_reg [SETS][WAYS];
    logic [WAY_BITS-1:0] cur_age [WAYS];
    logic [WAY_BITS-1:0] age_next [WAYS];
    logic [WAY_BITS-1:0] touched_age;
    logic [WAY_BITS-1:0] lru_way;
    logic [WAY_BITS-1:0] inv_way;
    logic                any_invalid;

    assign touched_age = cur_age[touch_way];

    // A touched way goes to age 0. Every way younger than it ages by one.
    // Older ways keep their age, so the set remains a permutation.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
            assign cur_age[gi] = age_reg[index][gi];
            assign age_next[gi] =
                (WAY_BITS'(gi) == touch_way)  ? '0 :
                (cur_age[gi] < touched_age)   ? cur_age[gi] + WAY_BITS'(1) :
                                                cur_age[gi];
        end
    endgenerate

    // The loops scan from the top way down, so the lowest index found last
    // is the one kept.
    always_comb begin
        lru_way     = '0;
        inv_way     = '0;
        any_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (cur_age[w] == WAY_BITS'(WAYS - 1)) begin
                lru_way = WAY_BITS'(w);
            end
            if (!set_valid[w]) begin
                any_invalid = 1'b1;
                inv_way     = WAY_BITS'(w);
            end
        end
        victim_way = any_invalid ? inv_way : lru_way;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_reg[s][w] <= WAY_BITS'(w);
                end
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                age_reg[index][w] <= age_next[w];
            end
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway
// N-way set-associative data-cache storage. It holds per-line valid, dirty,
// tag and data, with true-LRU replacement and victim reporting so the
// controller can write back a line before refill.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : request  req_i/we_i/index_i/tag_i/data_i/dirty_i
//                  response rsp_valid_o/hit_o/way_o/data_o/victim_*
// Compare, victim select and LRU update happen in the request cycle. All
// responses appear exactly one cycle later.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int SETS   = DEF_SETS,
    parameter int WAYS   = DEF_WAYS,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_sram_nway_if.slave  bus
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int IDX_BITS = $clog2(SETS);

    // Line state
    logic [WAYS-1:0]   valid_reg [SETS];
    logic [WAYS-1:0]   dirty_reg [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    // The data store has one port, addressed by {set, way}. A hit reads
    // the hit line. A miss reads the victim line. A refill writes the
    // victim line, and the read sees its pre-write contents.
    logic [LINE_W-1:0] data_mem  [SETS*WAYS];

    logic [WAYS-1:0]              set_valid;
    logic [WAYS-1:0]              set_dirty;
    logic [WAYS-1:0]              hit_vec;
    logic                         hit;
    logic [WAY_BITS-1:0]          hit_way;
    logic [WAY_BITS-1:0]          victim_way;
    logic [WAY_BITS-1:0]          sel_way;
    logic [IDX_BITS+WAY_BITS-1:0] mem_addr;
    logic                         write_en;
    logic                         touch;
    logic                         sel_valid;

    // Response registers
    logic                rsp_valid_reg;
    logic                hit_reg;
    logic [WAY_BITS-1:0] way_reg;
    logic                data_sel_reg;
    logic                victim_valid_reg;
    logic                victim_dirty_reg;
    logic [TAG_W-1:0]    victim_tag_reg;
    logic [LINE_W-1:0]   rd_data_reg;

    assign set_valid = valid_reg[bus.index_i];
    assign set_dirty = dirty_reg[bus.index_i];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign hit_vec[gi] = set_valid[gi] &&
                                 (tag_mem[bus.index_i][gi] == bus.tag_i);
        end
    endgenerate

    // Only one way should ever match. If several do, the lowest one wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    assign sel_way   = hit ? hit_way : victim_way;
    assign sel_valid = set_valid[sel_way];
    assign mem_addr  = {bus.index_i, sel_way};
    assign write_en  = bus.req_i && bus.we_i;
    // Lookup misses leave the replacement order alone.
    assign touch     = bus.req_i && (hit || bus.we_i);

    dcache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .index      (bus.index_i),
        .set_valid  (set_valid),
        .touch      (touch),
        .touch_way  (sel_way),
        .victim_way (victim_way)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
            end
        end else if (write_en) begin
            valid_reg[bus.index_i][sel_way] <= 1'b1;
            dirty_reg[bus.index_i][sel_way] <= hit ? (set_dirty[sel_way] | bus.dirty_i)
                                                   : bus.dirty_i;
        end
    end

    // Tag and data contents are not reset. A write that coincides with
    // reset is dropped along with the rest of that request.
    always_ff @(posedge clk_i) begin
        if (write_en && !rst_i) begin
            tag_mem[bus.index_i][sel_way] <= bus.tag_i;
            data_mem[mem_addr]            <= bus.data_i;
        end
        if (bus.req_i) begin
            rd_data_reg <= data_mem[mem_addr];
        end
    end

    // Victim tag and data are reported only when the victim line holds
    // valid contents. An empty way reads back as zero rather than as stale
    // storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_reg    <= 1'b0;
            hit_reg          <= 1'b0;
            way_reg          <= '0;
            data_sel_reg     <= 1'b0;
            victim_valid_reg <= 1'b0;
            victim_dirty_reg <= 1'b0;
            victim_tag_reg   <= '0;
        end else begin
            rsp_valid_reg <= bus.req_i;
            if (bus.req_i) begin
                hit_reg          <= hit;
                way_reg          <= sel_way;
                data_sel_reg     <= hit && !bus.we_i;
                victim_valid_reg <= !hit && sel_valid;
                victim_dirty_reg <= !hit && sel_valid && set_dirty[sel_way];
                victim_tag_reg   <= (!hit && sel_valid) ? tag_mem[bus.index_i][sel_way]
                                                        : '0;
            end
        end
    end

    assign bus.rsp_valid_o    = rsp_valid_reg;
    assign bus.hit_o          = hit_reg;
    assign bus.way_o          = way_reg;
    assign bus.data_o         = data_sel_reg ? rd_data_reg : '0;
    assign bus.victim_valid_o = victim_valid_reg;
    assign bus.victim_dirty_o = victim_dirty_reg;
    assign bus.victim_tag_o   = victim_tag_reg;
    assign bus.victim_data_o  = victim_valid_reg ? rd_data_reg : '0;

endmodule
